// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the datapath and the data-memory responder
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering req/ack loads and stores after LATENCY wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic     clk,
  input  logic     rst,
  data_mem_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        c_we, e_we, valid, enter_resp, err;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata, rdata;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  always_comb begin
    state_nx = state == IDLE ? (bus.req ? (LATENCY == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
             : IDLE;
  end
  // with zero latency the request is evaluated on its own accept edge, before the holding registers load
  assign e_we       = state == IDLE ? bus.we    : c_we;
  assign e_addr     = state == IDLE ? bus.addr  : c_addr;
  assign e_wdata    = state == IDLE ? bus.wdata : c_wdata;
  assign idx        = e_addr[AW+1:2];
  assign valid      = e_addr[1:0] == 2'b00 && e_addr < 32'(4 * DEPTH_WORDS);
  assign enter_resp = state_nx == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req) begin
        c_we    <= bus.we;
        c_addr  <= bus.addr;
        c_wdata <= bus.wdata;
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      err <= enter_resp && !valid;
      if (enter_resp && (!valid || !e_we)) rdata <= valid ? mem[idx] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && valid && e_we) mem[idx] <= e_wdata;
  end
  assign bus.ack   = state == RESP;
  assign bus.busy  = state != IDLE;
  assign bus.err   = err;
  assign bus.rdata = rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
`timescale 1ns/1ps
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_if b2 ();
  data_mem_if b0 ();
  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  int checks = 0;
  int errors = 0;
  int r_acks, r_at, r_busy;
  logic [31:0] r_rdata;
  logic r_err;
  bit sel = 1'b0;
  wire s_ack = sel ? b0.ack : b2.ack;
  wire s_err = sel ? b0.err : b2.err;
  wire s_busy = sel ? b0.busy : b2.busy;
  wire [31:0] s_rdata = sel ? b0.rdata : b2.rdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit z, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (z) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask
  // poke>0 strobes a stray load of 0x04 in that cycle after the accept edge
  task automatic access(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d, input int poke);
    sel = z;
    @(negedge clk);
    drive(z, 1'b1, w, a, d);
    r_acks = 0; r_at = 0; r_busy = 0; r_rdata = 'x; r_err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (s_ack) begin
        r_acks++; r_at = i; r_rdata = s_rdata; r_err = s_err;
      end
      if (s_busy) r_busy++;
      if (i == poke) drive(z, 1'b1, 1'b0, 32'h4, 32'hBAD0BAD0);
      else drive(z, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask
  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy2", 32'(b2.busy), 32'd0);
    chk("rst_ack2", 32'(b2.ack), 32'd0);
    chk("rst_err2", 32'(b2.err), 32'd0);
    chk("rst_rdata2", b2.rdata, 32'h0);
    chk("rst_busy0", 32'(b0.busy), 32'd0);
    chk("rst_rdata0", b0.rdata, 32'h0);
    rst = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midop_busy", 32'(b2.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midop_busy_async", 32'(b2.busy), 32'd0);
    chk("midop_ack_async", 32'(b2.ack), 32'd0);
    r_acks = 0;
    repeat (2) begin @(negedge clk); if (b2.ack) r_acks++; end
    rst = 1'b0;
    repeat (5) begin @(negedge clk); if (b2.ack) r_acks++; end
    chk("midop_noack", 32'(r_acks), 32'd0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 0);
    chk("midop_load", r_rdata, 32'h0);
    chk("midop_load_err", 32'(r_err), 32'd0);
    access(1'b0, 1'b1, 32'h4, 32'h12345678, 0);
    chk("st4_acks", 32'(r_acks), 32'd1);
    chk("st4_at", 32'(r_at), 32'd3);
    chk("st4_busy", 32'(r_busy), 32'd3);
    chk("st4_err", 32'(r_err), 32'd0);
    access(1'b0, 1'b0, 32'h4, 32'h0, 0);
    chk("ld4_acks", 32'(r_acks), 32'd1);
    chk("ld4_at", 32'(r_at), 32'd3);
    chk("ld4_rdata", r_rdata, 32'h12345678);
    chk("ld4_err", 32'(r_err), 32'd0);
    access(1'b1, 1'b1, 32'hFC, 32'hCAFEF00D, 0);
    chk("z_st_acks", 32'(r_acks), 32'd1);
    chk("z_st_at", 32'(r_at), 32'd1);
    chk("z_st_busy", 32'(r_busy), 32'd1);
    chk("z_st_err", 32'(r_err), 32'd0);
    access(1'b1, 1'b0, 32'hFC, 32'h0, 0);
    chk("z_ld_at", 32'(r_at), 32'd1);
    chk("z_ld_busy", 32'(r_busy), 32'd1);
    chk("z_ld_rdata", r_rdata, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 0);
    chk("mis_acks", 32'(r_acks), 32'd1);
    chk("mis_err", 32'(r_err), 32'd1);
    chk("mis_rdata", r_rdata, 32'h0);
    access(1'b0, 1'b0, 32'h4, 32'h0, 0);
    chk("mis_ld4", r_rdata, 32'h12345678);
    chk("mis_ld4_err", 32'(r_err), 32'd0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("oor_ld_err", 32'(r_err), 32'd1);
    chk("oor_ld_rdata", r_rdata, 32'h0);
    access(1'b0, 1'b1, 32'h100, 32'hAAAA5555, 0);
    chk("oor_st_err", 32'(r_err), 32'd1);
    access(1'b0, 1'b0, 32'h80000004, 32'h0, 0);
    chk("oor_hi_err", 32'(r_err), 32'd1);
    chk("oor_hi_rdata", r_rdata, 32'h0);
    access(1'b0, 1'b0, 32'h0, 32'h0, 0);
    chk("oor_word0", r_rdata, 32'h0);
    access(1'b0, 1'b0, 32'hFC, 32'h0, 0);
    chk("oor_word63", r_rdata, 32'h0);
    access(1'b0, 1'b0, 32'h4, 32'h0, 0);
    chk("oor_word1", r_rdata, 32'h12345678);
    access(1'b0, 1'b1, 32'h8, 32'h11112222, 1);
    chk("drop_acks", 32'(r_acks), 32'd1);
    chk("drop_at", 32'(r_at), 32'd3);
    chk("drop_err", 32'(r_err), 32'd0);
    chk("drop_rdata_held", b2.rdata, 32'h12345678);
    access(1'b0, 1'b0, 32'h8, 32'h0, 0);
    chk("drop_ld8", r_rdata, 32'h11112222);
    access(1'b0, 1'b0, 32'h4, 32'h0, 0);
    chk("drop_ld4", r_rdata, 32'h12345678);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
